vga_bus_arbiter: RTL and testbench

Two-master memory arbiter that sits between the shared 64 KiB byte-wide synchronous RAM and its two bus masters: the VGA text fetch engine and the CPU. It is the responder to the VGA master's protocol. The VGA master announces each memory cycle one clock ahead on its access line, so the VGA side always gets the cycle it announced. CPU requests are latched, deferred around VGA cycles, executed in a free cycle and acknowledged with a one-cycle ack pulse.

---
 rtl/vga_bus_arbiter.sv | 103 ++++++++++
 tb/tb_vga_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bus_arbiter.sv
// vga_bus_arbiter: two-master RAM arbiter giving announced VGA cycles priority over deferred CPU requests
// Ports:
//   i_clk, i_reset         clock and synchronous active-high reset
//   i_vga_*                VGA read master (access announces next-cycle cs)
//   o_vga_dat, o_vga_err   VGA read data (combinational) and sticky protocol error
//   i_cpu_*                CPU request, held until ack
//   o_cpu_dat, o_cpu_ack   registered read data and one-cycle completion pulse
//   o_mem_*, i_mem_dat     synchronous RAM port (read data one cycle after cs)
module vga_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_vga_addr,
    input  logic                  i_vga_cs,
    input  logic                  i_vga_access,
    output logic [DATA_WIDTH-1:0] o_vga_dat,
    output logic                  o_vga_err,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_dat,
    input  logic                  i_cpu_cs,
    input  logic                  i_cpu_we,
    output logic [DATA_WIDTH-1:0] o_cpu_dat,
    output logic                  o_cpu_ack,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_dat,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_dat
);
    typedef enum logic [2:0] {IDLE, PEND, MEM, RD, ACK} state_t;
    state_t                state_q, state_d;
    logic                  vga_owns_q, vga_owns_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_dat_q, req_dat_d;
    logic                  req_we_q, req_we_d;
    logic [DATA_WIDTH-1:0] cpu_dat_q, cpu_dat_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  vga_err_q, vga_err_d;
    logic                  cpu_cycle, vga_cycle;
    always_comb begin
        state_d    = state_q;
        vga_owns_d = i_vga_access;
        req_addr_d = req_addr_q;
        req_dat_d  = req_dat_q;
        req_we_d   = req_we_q;
        cpu_dat_d  = cpu_dat_q;
        cpu_ack_d  = 1'b0;
        vga_err_d  = vga_err_q | (i_vga_cs & ~vga_owns_q);
        case (state_q)
            IDLE: begin
                if (i_cpu_cs) begin
                    req_addr_d = i_cpu_addr;
                    req_dat_d  = i_cpu_dat;
                    req_we_d   = i_cpu_we;
                    state_d    = i_vga_access ? PEND : MEM;
                end
            end
            PEND: state_d = i_vga_access ? PEND : MEM;
            MEM:  state_d = RD;
            RD: begin
                cpu_dat_d = i_mem_dat;
                cpu_ack_d = 1'b1;
                state_d   = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            vga_owns_q <= 1'b0;
            req_addr_q <= '0;
            req_dat_q  <= '0;
            req_we_q   <= 1'b0;
            cpu_dat_q  <= '0;
            cpu_ack_q  <= 1'b0;
            vga_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vga_owns_q <= vga_owns_d;
            req_addr_q <= req_addr_d;
            req_dat_q  <= req_dat_d;
            req_we_q   <= req_we_d;
            cpu_dat_q  <= cpu_dat_d;
            cpu_ack_q  <= cpu_ack_d;
            vga_err_q  <= vga_err_d;
        end
    end
    // MEM is never entered in a VGA-owned cycle, so a VGA cs during MEM is a violation and loses
    assign cpu_cycle  = state_q == MEM;
    assign vga_cycle  = ~cpu_cycle & vga_owns_q & i_vga_cs;
    assign o_mem_cs   = cpu_cycle | vga_cycle;
    assign o_mem_we   = cpu_cycle & req_we_q;
    assign o_mem_addr = cpu_cycle ? req_addr_q : vga_cycle ? i_vga_addr : '0;
    assign o_mem_dat  = cpu_cycle ? req_dat_q : '0;
    assign o_vga_dat  = i_mem_dat;
    assign o_cpu_dat  = cpu_dat_q;
    assign o_cpu_ack  = cpu_ack_q;
    assign o_vga_err  = vga_err_q;
endmodule

// File: tb/tb_vga_bus_arbiter.sv
// tb_vga_bus_arbiter: self-checking bench for vga_bus_arbiter with a RAM model and reference memory
module tb_vga_bus_arbiter;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_vga_addr;
    logic        i_vga_cs;
    logic        i_vga_access;
    logic [7:0]  o_vga_dat;
    logic        o_vga_err;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dat;
    logic        i_cpu_cs;
    logic        i_cpu_we;
    logic [7:0]  o_cpu_dat;
    logic        o_cpu_ack;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_dat;
    logic        o_mem_cs;
    logic        o_mem_we;
    logic [7:0]  i_mem_dat;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    vga_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_vga_addr(i_vga_addr), .i_vga_cs(i_vga_cs), .i_vga_access(i_vga_access),
        .o_vga_dat(o_vga_dat), .o_vga_err(o_vga_err),
        .i_cpu_addr(i_cpu_addr), .i_cpu_dat(i_cpu_dat), .i_cpu_cs(i_cpu_cs), .i_cpu_we(i_cpu_we),
        .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack),
        .o_mem_addr(o_mem_addr), .o_mem_dat(o_mem_dat), .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we),
        .i_mem_dat(i_mem_dat)
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // synchronous RAM: unwritten locations read back a fixed address pattern
    bit   [7:0]  ram [65536];
    bit          wr  [65536];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_dat = '0;
    logic [7:0]  rdata = '0;
    assign i_mem_dat = rdata;
    always @(posedge i_clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_dat;
            wr[ld_addr]  <= 1'b1;
        end else if (o_mem_cs) begin
            if (o_mem_we) begin
                ram[o_mem_addr] <= o_mem_dat;
                wr[o_mem_addr]  <= 1'b1;
            end
            rdata <= wr[o_mem_addr] ? ram[o_mem_addr] : pat(o_mem_addr);
        end
    end

    // reference view of memory contents, updated when a transaction completes
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] exp_mem(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    task automatic idle_inputs;
        i_vga_addr = '0; i_vga_cs = 1'b0; i_vga_access = 1'b0;
        i_cpu_addr = '0; i_cpu_dat = '0; i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        step;
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        ref_mem[int'(a)] = d;
        step;
        ld_en = 1'b0;
    endtask

    // uncontended CPU transaction; lat is cycles from cs to ack, -1 when no ack arrives
    task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic we,
                          output int lat, output logic [7:0] rd, output int we_cyc);
        lat = -1; rd = '0; we_cyc = 0;
        for (int k = 0; k < 12; k++) begin
            step;
            i_cpu_cs = 1'b1; i_cpu_addr = a; i_cpu_dat = d; i_cpu_we = we;
            settle;
            if (o_mem_we) we_cyc++;
            if (o_cpu_ack) begin
                lat = k;
                rd = o_cpu_dat;
                break;
            end
        end
        step;
        i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
        if (lat >= 0 && we) ref_mem[int'(a)] = d;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        idle_inputs();
        step; step;
        settle;
        tests++; if (o_cpu_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", o_cpu_ack); end
        tests++; if (o_cpu_dat !== 8'h00) begin fails++; $display("FAIL reset_cpu_dat: got %h want 00", o_cpu_dat); end
        tests++; if (o_vga_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_vga_err); end
        tests++; if ({o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat} !== 26'd0)
            begin fails++; $display("FAIL reset_mem: got cs=%b we=%b a=%h d=%h want all 0", o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat); end
        step;
        i_reset = 1'b0;
    endtask

    task automatic test_uncontended_read;
        load(16'h1234, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            step;
            i_cpu_cs = (k <= 3); i_cpu_addr = 16'h1234; i_cpu_we = 1'b0; i_cpu_dat = 8'h00;
            settle;
            if (k == 1) begin
                tests++;
                if ({o_mem_cs, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 16'h1234})
                    begin fails++; $display("FAIL ur_mem_cycle: got cs=%b we=%b a=%h want 1 0 1234", o_mem_cs, o_mem_we, o_mem_addr); end
            end
            if (k == 0 || k == 2) begin
                tests++; if (o_mem_cs !== 1'b0) begin fails++; $display("FAIL ur_mem_idle k=%0d: got %b want 0", k, o_mem_cs); end
            end
            tests++;
            if (o_cpu_ack !== (k == 3)) begin fails++; $display("FAIL ur_ack k=%0d: got %b want %b", k, o_cpu_ack, k == 3); end
            if (k == 3) begin
                tests++; if (o_cpu_dat !== 8'h5A) begin fails++; $display("FAIL ur_data: got %h want 5a", o_cpu_dat); end
            end
        end
        i_cpu_cs = 1'b0;
    endtask

    task automatic test_write_read;
        int lat, wc;
        logic [7:0] rd;
        cpu_op(16'h0FFF, 8'hA5, 1'b1, lat, rd, wc);
        tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
        tests++; if (wc !== 1) begin fails++; $display("FAIL wr_we_cycles: got %0d want 1", wc); end
        cpu_op(16'h0FFF, 8'h00, 1'b0, lat, rd, wc);
        tests++; if (lat !== 3) begin fails++; $display("FAIL rb_latency: got %0d want 3", lat); end
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL rb_data: got %h want a5", rd); end
        tests++; if (wc !== 0) begin fails++; $display("FAIL rb_we_cycles: got %0d want 0", wc); end
    endtask

    task automatic test_contention;
        logic [15:0] a;
        a = {4'h2, 12'($urandom)};
        for (int k = 0; k < 8; k++) begin
            step;
            i_vga_access = (k <= 2);
            i_vga_cs = (k >= 1 && k <= 3);
            i_vga_addr = i_vga_cs ? 16'h1000 : 16'h0000;
            i_cpu_cs = (k <= 6); i_cpu_addr = a; i_cpu_we = 1'b0;
            settle;
            if (k >= 1 && k <= 3) begin
                tests++;
                if ({o_mem_cs, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 16'h1000})
                    begin fails++; $display("FAIL ct_vga_grant k=%0d: got cs=%b we=%b a=%h want 1 0 1000", k, o_mem_cs, o_mem_we, o_mem_addr); end
            end
            if (k == 4) begin
                tests++;
                if ({o_mem_cs, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, a})
                    begin fails++; $display("FAIL ct_cpu_mem: got cs=%b we=%b a=%h want 1 0 %h", o_mem_cs, o_mem_we, o_mem_addr, a); end
            end
            if (k == 0 || k >= 5) begin
                tests++; if (o_mem_cs !== 1'b0) begin fails++; $display("FAIL ct_mem_idle k=%0d: got %b want 0", k, o_mem_cs); end
            end
            if (k >= 2 && k <= 4) begin
                tests++;
                if (o_vga_dat !== exp_mem(16'h1000)) begin fails++; $display("FAIL ct_vga_data k=%0d: got %h want %h", k, o_vga_dat, exp_mem(16'h1000)); end
            end
            tests++;
            if (o_cpu_ack !== (k == 6)) begin fails++; $display("FAIL ct_ack k=%0d: got %b want %b", k, o_cpu_ack, k == 6); end
            if (k == 6) begin
                tests++; if (o_cpu_dat !== exp_mem(a)) begin fails++; $display("FAIL ct_cpu_data: got %h want %h", o_cpu_dat, exp_mem(a)); end
            end
            tests++; if (o_vga_err !== 1'b0) begin fails++; $display("FAIL ct_err k=%0d: got %b want 0", k, o_vga_err); end
        end
        idle_inputs();
    endtask

    // VGA reads the upper half of memory, CPU the lower half, so VGA data never depends on CPU writes
    task automatic test_vga_pattern;
        localparam int N = 10000;
        bit busy = 1'b0, drop = 1'b0, vga_pend = 1'b0;
        int start = 0, lat, el;
        logic [15:0] ca = '0;
        logic [7:0] cd = '0, vga_exp = '0;
        logic cw = 1'b0;
        for (int t = 0; t < N + 16; t++) begin
            step;
            i_vga_access = ((t % 8) == 3) || ((t % 8) == 5);
            i_vga_cs = ((t % 8) == 4) || ((t % 8) == 6);
            i_vga_addr = i_vga_cs ? {1'b1, 15'($urandom)} : 16'h0000;
            if (drop) begin
                i_cpu_cs = 1'b0; i_cpu_we = 1'b0; drop = 1'b0;
            end else if (!busy && t < N && $urandom_range(0, 2) == 0) begin
                busy = 1'b1; start = t;
                ca = {1'b0, 15'($urandom)}; cd = 8'($urandom); cw = 1'($urandom);
                i_cpu_cs = 1'b1; i_cpu_addr = ca; i_cpu_dat = cd; i_cpu_we = cw;
            end
            settle;
            if (vga_pend) begin
                tests++;
                if (o_vga_dat !== vga_exp) begin fails++; $display("FAIL vp_vga_data t=%0d: got %h want %h", t, o_vga_dat, vga_exp); end
                vga_pend = 1'b0;
            end
            if (i_vga_cs) begin
                tests++;
                if ({o_mem_cs, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, i_vga_addr})
                    begin fails++; $display("FAIL vp_vga_grant t=%0d: got cs=%b we=%b a=%h want 1 0 %h", t, o_mem_cs, o_mem_we, o_mem_addr, i_vga_addr); end
                vga_pend = 1'b1;
                vga_exp = exp_mem(i_vga_addr);
            end
            if (o_cpu_ack) begin
                tests++;
                if (!busy) begin
                    fails++; $display("FAIL vp_spurious_ack t=%0d: got 1 want 0", t);
                end else begin
                    lat = t - start;
                    el = 3;
                    for (int j = start; ((j % 8) == 3) || ((j % 8) == 5); j++) el++;
                    if (lat != el || lat > 6) begin fails++; $display("FAIL vp_latency t=%0d: got %0d want %0d", t, lat, el); end
                    if (!cw) begin
                        tests++;
                        if (o_cpu_dat !== exp_mem(ca)) begin fails++; $display("FAIL vp_cpu_data a=%h: got %h want %h", ca, o_cpu_dat, exp_mem(ca)); end
                    end else begin
                        ref_mem[int'(ca)] = cd;
                    end
                    busy = 1'b0; drop = 1'b1;
                end
            end else if (busy && t - start > 8) begin
                tests++; fails++;
                $display("FAIL vp_timeout t=%0d: got no ack want ack within 6", t);
                busy = 1'b0; drop = 1'b1;
            end
        end
        tests++; if (o_vga_err !== 1'b0) begin fails++; $display("FAIL vp_err: got %b want 0", o_vga_err); end
        idle_inputs();
    endtask

    task automatic test_violation;
        logic [15:0] a = 16'h0456;
        logic [7:0]  d = 8'h77;
        for (int k = 0; k < 5; k++) begin
            step;
            i_vga_access = 1'b0;
            i_vga_cs = (k == 1); i_vga_addr = (k == 1) ? 16'hBEEF : 16'h0000;
            i_cpu_cs = (k <= 3); i_cpu_addr = a; i_cpu_dat = d; i_cpu_we = 1'b1;
            settle;
            if (k == 1) begin
                tests++;
                if ({o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat} !== {1'b1, 1'b1, a, d})
                    begin fails++; $display("FAIL vi_cpu_wins: got cs=%b we=%b a=%h d=%h want 1 1 %h %h", o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat, a, d); end
            end
            tests++;
            if (o_vga_err !== (k >= 2)) begin fails++; $display("FAIL vi_err k=%0d: got %b want %b", k, o_vga_err, k >= 2); end
            if (k == 3) begin
                tests++; if (o_cpu_ack !== 1'b1) begin fails++; $display("FAIL vi_ack: got %b want 1", o_cpu_ack); end
            end
        end
        ref_mem[int'(a)] = d;
        i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
        step;
        i_vga_cs = 1'b1; i_vga_addr = 16'hBEEF;
        settle;
        tests++; if (o_mem_cs !== 1'b0) begin fails++; $display("FAIL vi_not_granted: got %b want 0", o_mem_cs); end
        step;
        i_vga_cs = 1'b0; i_vga_addr = '0;
        step; step; step;
        settle;
        tests++; if (o_vga_err !== 1'b1) begin fails++; $display("FAIL vi_sticky: got %b want 1", o_vga_err); end
    endtask

    task automatic test_reset_mid;
        int lat, wc;
        logic [7:0] rd;
        logic [15:0] a = 16'h0321;
        for (int k = 0; k < 5; k++) begin
            step;
            i_reset = (k == 2);
            i_cpu_cs = (k <= 2); i_cpu_addr = a; i_cpu_we = 1'b0;
            settle;
            if (k == 1) begin
                tests++; if (o_mem_cs !== 1'b1) begin fails++; $display("FAIL rm_mem: got %b want 1", o_mem_cs); end
            end
            if (k == 3) begin
                tests++; if (o_mem_cs !== 1'b0) begin fails++; $display("FAIL rm_mem_cs: got %b want 0", o_mem_cs); end
                tests++; if (o_vga_err !== 1'b0) begin fails++; $display("FAIL rm_err: got %b want 0", o_vga_err); end
                tests++; if (o_cpu_dat !== 8'h00) begin fails++; $display("FAIL rm_cpu_dat: got %h want 00", o_cpu_dat); end
            end
            if (k >= 3) begin
                tests++; if (o_cpu_ack !== 1'b0) begin fails++; $display("FAIL rm_no_ack k=%0d: got %b want 0", k, o_cpu_ack); end
            end
        end
        cpu_op(a, 8'h00, 1'b0, lat, rd, wc);
        tests++; if (lat !== 3) begin fails++; $display("FAIL rm_retry_latency: got %0d want 3", lat); end
        tests++; if (rd !== exp_mem(a)) begin fails++; $display("FAIL rm_retry_data: got %h want %h", rd, exp_mem(a)); end
    endtask

    task automatic test_back_to_back;
        int lat, wc;
        logic [7:0] rd, d;
        logic [15:0] a;
        logic we;
        for (int i = 0; i < 8; i++) begin
            a = {3'b000, 2'(i % 3), 11'($urandom)};
            d = 8'($urandom);
            we = (i % 2) == 0;
            cpu_op(a, d, we, lat, rd, wc);
            tests++; if (lat !== 3) begin fails++; $display("FAIL b2b_latency i=%0d: got %0d want 3", i, lat); end
            if (!we) begin
                tests++; if (rd !== exp_mem(a)) begin fails++; $display("FAIL b2b_data i=%0d a=%h: got %h want %h", i, a, rd, exp_mem(a)); end
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_uncontended_read();
        test_write_read();
        test_contention();
        test_vga_pattern();
        test_violation();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
